uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the Uart8 receiver. Captures each byte the receiver completes (rxOut qualified by rxDone), tags it with the receiver's frame-error flag, and queues it for a slower consumer. Reports occupancy, overflow and a count of framing errors.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2.
ADDR_WIDTH, 4, log2(DEPTH); the integrator keeps it consistent with DEPTH.
DROP_ERR, 0, 1 = discard bytes flagged by rxErr instead of storing them.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rxDone  in  1  receiver done flag; may be a single-cycle pulse or held high
rxErr  in  1  receiver error flag, sampled together with rxDone
rxByte  in  8  received byte, connects to Uart8 rxOut
rdEn  in  1  consumer read request
rdByte  out  8  read data, registered
rdErr  out  1  error tag of the byte on rdByte
rdValid  out  1  one-cycle strobe: rdByte/rdErr hold a new entry
empty  out  1  no stored entries
full  out  1  DEPTH entries stored
count  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH
overflow  out  1  sticky: a byte was lost because the FIFO was full
clrOverflow  in  1  clears overflow
errCount  out  8  saturating count of rxErr-tagged bytes received

Behaviour:
- Reset (async, any time, including mid-transfer):
  - wrPtr=0, rdPtr=0, count=0, empty=1, full=0, overflow=0.
  - rdValid=0, rdByte=0, rdErr=0, errCount=0, doneQ=0.
  - Storage contents are don't-care.
- Write event (wrEv): rxDone=1 and doneQ=0, where doneQ is rxDone registered each cycle. Exactly one write per rxDone rising edge, whether rxDone is a pulse or held high.
- On wrEv:
  - If rxErr=1, errCount increments, saturating at 255. This happens even when the byte is dropped.
  - If DROP_ERR=1 and rxErr=1, nothing is stored.
  - Otherwise {rxErr, rxByte} is written at wrPtr, and wrPtr increments modulo DEPTH.
- Read (rdEn=1 and empty=0 at the clock edge):
  - On that edge, rdByte/rdErr load mem[rdPtr], rdPtr increments modulo DEPTH, and rdValid=1 for one cycle.
  - Latency is 1 clock from rdEn to rdValid.
  - rdEn while empty is ignored: rdValid=0 and rdByte/rdErr hold their previous values.
- Simultaneous write and read:
  - Not full, not empty: both happen; count unchanged.
  - Full: both happen (the read frees a slot in the same edge); no overflow; count stays DEPTH.
  - Empty: only the write happens; no bypass; rdValid=0; count becomes 1.
- A write attempt when full without a read: the byte is discarded, overflow is set, and pointers and count are unchanged.
- overflow: a set event and clrOverflow in the same cycle leave it set (set wins).
- count, empty and full are registered and updated on the same edge as the pointer changes. empty = (count==0), full = (count==DEPTH).
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap DEPTH-1 → 0 with no gap.

Test Plan:
- Reset then idle → empty=1, count=0, rdValid=0, overflow=0, errCount=0. Assert reset mid-stream with count=5 → all outputs return to reset values asynchronously.
- rxDone held high 10 cycles with rxByte=8'h35 → count=1 (single write). rdEn one cycle → next cycle rdValid=1, rdByte=8'h35, rdErr=0, empty=1.
- Write 16 bytes 8'h00..8'h0F, then a 17th 8'hAA → full=1, count=16, overflow=1. Read 16 → data 00..0F in order with no AA; 17th rdEn gives rdValid=0.
- Full FIFO, wrEv and rdEn on the same edge with byte 8'h5A → overflow stays 0, count=16. After reading all entries, 8'h5A is the last byte out.
- rxErr=1 on byte 8'hC3:
  - DROP_ERR=0: stored with rdErr=1, errCount=1.
  - DROP_ERR=1: not stored, count unchanged, errCount=1.
  - 300 error bytes: errCount saturates at 255.
- Empty FIFO, wrEv and rdEn on the same edge → rdValid=0, count=1. Then clrOverflow together with an overflow event → overflow remains 1; clrOverflow alone → overflow=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and consumer-side signals of the UART receive FIFO.
// The master side is the receiver/consumer; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_WIDTH = 4
) ();
  logic                  rxDone;
  logic                  rxErr;
  logic [7:0]            rxByte;
  logic                  rdEn;
  logic                  clrOverflow;
  logic [7:0]            rdByte;
  logic                  rdErr;
  logic                  rdValid;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic [7:0]            errCount;

  modport master (
    output rxDone, rxErr, rxByte, rdEn, clrOverflow,
    input  rdByte, rdErr, rdValid, empty, full, count, overflow, errCount
  );

  modport slave (
    input  rxDone, rxErr, rxByte, rdEn, clrOverflow,
    output rdByte, rdErr, rdValid, empty, full, count, overflow, errCount
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-detected byte capture with
// error tagging, registered read port, sticky overflow and error counter.
module uart_rx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter bit          DROP_ERR   = 1'b0
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [8:0]    mem [DEPTH];

  logic          done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    rd_byte_q, rd_byte_d;
  logic          rd_err_q, rd_err_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          wr_ev;
  logic          store;
  logic          rd;
  logic          wr_ok;

  // Next-state: write on rxDone rising edge, read when non-empty; a read
  // on the same edge frees the slot a full-FIFO write needs.
  always_comb begin
    wr_ev      = bus.rxDone & ~done_q;
    store      = wr_ev & ~(DROP_ERR & bus.rxErr);
    rd         = bus.rdEn & ~empty_q;
    wr_ok      = store & (~full_q | rd);

    done_d     = bus.rxDone;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    rd_byte_d  = rd_byte_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd) begin
      rd_byte_d  = mem[rd_ptr_q][7:0];
      rd_err_d   = mem[rd_ptr_q][8];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(wr_ok) - CW'(rd);
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));

    // Set wins over clear.
    if (store && full_q && !rd) begin
      overflow_d = 1'b1;
    end else if (bus.clrOverflow) begin
      overflow_d = 1'b0;
    end

    if (wr_ev && bus.rxErr && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_byte_q  <= 8'h00;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      rd_byte_q  <= rd_byte_d;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= rd_valid_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage has no reset; contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= {bus.rxErr, bus.rxByte};
    end
  end

  assign bus.rdByte   = rd_byte_q;
  assign bus.rdErr    = rd_err_q;
  assign bus.rdValid  = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.errCount = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one keep-errors and one drop-errors instance share
// stimulus; each is compared every cycle against a queue-based model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       reset;
  logic       rx_done, rx_err, rd_en, clr_ovf;
  logic [7:0] rx_byte;

  int n_chk;
  int n_err;

  uart_rx_fifo_if #(.ADDR_WIDTH(4)) if0 ();
  uart_rx_fifo_if #(.ADDR_WIDTH(4)) if1 ();

  assign if0.rxDone = rx_done;      assign if1.rxDone = rx_done;
  assign if0.rxErr = rx_err;        assign if1.rxErr = rx_err;
  assign if0.rxByte = rx_byte;      assign if1.rxByte = rx_byte;
  assign if0.rdEn = rd_en;          assign if1.rdEn = rd_en;
  assign if0.clrOverflow = clr_ovf; assign if1.clrOverflow = clr_ovf;

  uart_rx_fifo #(.DEPTH(16), .ADDR_WIDTH(4), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  uart_rx_fifo #(.DEPTH(16), .ADDR_WIDTH(4), .DROP_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: index 0 keeps error bytes, index 1 drops them.
  logic [8:0] mq [2][$];
  logic [7:0] m_byte [2];
  logic       m_err [2];
  logic       m_valid [2];
  logic       m_ovf [2];
  int         m_ec [2];
  logic       m_done;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_byte[k] = 8'h00; m_err[k] = 1'b0; m_valid[k] = 1'b0;
      m_ovf[k] = 1'b0;   m_ec[k] = 0;
    end
    m_done = 1'b0;
  endtask

  task automatic model_clock();
    logic ev;
    logic [8:0] e;
    logic set;
    ev = rx_done && !m_done;
    m_done = rx_done;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      set = 1'b0;
      if (rd_en && mq[k].size() > 0) begin
        e = mq[k].pop_front();
        m_byte[k] = e[7:0];
        m_err[k] = e[8];
        m_valid[k] = 1'b1;
      end
      if (ev) begin
        if (rx_err && m_ec[k] < 255) m_ec[k]++;
        if (!(k == 1 && rx_err)) begin
          if (mq[k].size() < DEPTH) mq[k].push_back({rx_err, rx_byte});
          else set = 1'b1;
        end
      end
      if (set) m_ovf[k] = 1'b1;
      else if (clr_ovf) m_ovf[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k, input logic [7:0] rb, input logic re, input logic rv,
                           input logic [4:0] cnt, input logic emp, input logic ful,
                           input logic ovf, input logic [7:0] ec);
    string p;
    p = (k == 0) ? "d0" : "d1";
    check({p, ".rdValid"}, 32'(rv), 32'(m_valid[k]));
    check({p, ".rdByte"}, 32'(rb), 32'(m_byte[k]));
    check({p, ".rdErr"}, 32'(re), 32'(m_err[k]));
    check({p, ".count"}, 32'(cnt), 32'(mq[k].size()));
    check({p, ".empty"}, 32'(emp), 32'(mq[k].size() == 0));
    check({p, ".full"}, 32'(ful), 32'(mq[k].size() == DEPTH));
    check({p, ".overflow"}, 32'(ovf), 32'(m_ovf[k]));
    check({p, ".errCount"}, 32'(ec), 32'(m_ec[k]));
  endtask

  task automatic check_both();
    check_dut(0, if0.rdByte, if0.rdErr, if0.rdValid, if0.count, if0.empty, if0.full,
              if0.overflow, if0.errCount);
    check_dut(1, if1.rdByte, if1.rdErr, if1.rdValid, if1.count, if1.empty, if1.full,
              if1.overflow, if1.errCount);
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic cyc(input logic d, input logic e, input logic [7:0] b,
                     input logic r, input logic c);
    rx_done = d; rx_err = e; rx_byte = b; rd_en = r; clr_ovf = c;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_both();
  endtask

  task automatic wr(input logic [7:0] b, input logic e);
    cyc(1'b1, e, b, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, b, 1'b0, 1'b0);
  endtask

  // Asserted away from any clock edge so the async clear is observed directly.
  task automatic apply_reset();
    rx_done = 1'b0; rx_err = 1'b0; rx_byte = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_both();
    check("rst.count", 32'(if0.count), 32'd0);
    check("rst.empty", 32'(if0.empty), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Held rxDone gives exactly one write.
    repeat (10) cyc(1'b1, 1'b0, 8'h35, 1'b0, 1'b0);
    check("held.count", 32'(if0.count), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("held.rdValid", 32'(if0.rdValid), 32'd1);
    check("held.rdByte", 32'(if0.rdByte), 32'h35);
    check("held.empty", 32'(if0.empty), 32'd1);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    wr(8'hAA, 1'b0);
    check("fill.full", 32'(if0.full), 32'd1);
    check("fill.count", 32'(if0.count), 32'd16);
    check("fill.overflow", 32'(if0.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("drain.byte", 32'(if0.rdByte), 32'(i));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain.empty_rd", 32'(if0.rdValid), 32'd0);

    // Full FIFO with simultaneous write and read.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 1'b0);
    cyc(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    check("fullrw.overflow", 32'(if0.overflow), 32'd0);
    check("fullrw.count", 32'(if0.count), 32'd16);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("fullrw.last", 32'(if0.rdByte), 32'h5A);

    // Error-tagged byte: kept by dut0, dropped by dut1.
    apply_reset();
    wr(8'hC3, 1'b1);
    check("err.count0", 32'(if0.count), 32'd1);
    check("err.count1", 32'(if1.count), 32'd0);
    check("err.ec0", 32'(if0.errCount), 32'd1);
    check("err.ec1", 32'(if1.errCount), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("err.rdErr0", 32'(if0.rdErr), 32'd1);
    check("err.rdByte0", 32'(if0.rdByte), 32'hC3);
    check("err.rdValid1", 32'(if1.rdValid), 32'd0);

    // Empty FIFO with simultaneous write and read: no bypass.
    cyc(1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    check("emptyrw.rdValid", 32'(if0.rdValid), 32'd0);
    check("emptyrw.count", 32'(if0.count), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Overflow set beats clear; clear alone works.
    for (int i = 0; i < 15; i++) wr(8'(i), 1'b0);
    cyc(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    check("ovf.setwins", 32'(if0.overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf.clear", 32'(if0.overflow), 32'd0);

    // Reset mid-stream with entries stored.
    apply_reset();
    for (int i = 0; i < 5; i++) wr(8'(8'h90 + i), 1'b0);
    check("mid.count5", 32'(if0.count), 32'd5);
    apply_reset();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("sat.ec0", 32'(if0.errCount), 32'd255);
    check("sat.ec1", 32'(if1.errCount), 32'd255);

    // Random traffic.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 8'($urandom),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
